kbd_decoder: RTL
================

# kbd_decoder

PS/2 scancode decoder between `ps2_keyboard` (raw byte FIFO) and consumers such as the text-mode display writer and the seven-segment status logic. It pops bytes from the keyboard FIFO and tracks the break (`F0`) and extended (`E0`) prefixes. It also tracks Shift and Caps Lock state, and emits one key-press event per make code (ASCII, scancode, extended flag) over a valid/ready handshake. A running press counter is provided for display.

## Interface
- No parameters.
- `clk` in 1: system clock, the same clock as `ps2_keyboard`.
- `resetn` in 1: asynchronous, active-low reset.
- `in_data` in 8: byte at the head of the keyboard FIFO.
- `in_ready` in 1: keyboard FIFO is non-empty.
- `in_overflow` in 1: keyboard FIFO overflow flag.
- `nextdata_n` out 1: active-low pop strobe to `ps2_keyboard`.
- `out_valid` out 1: key event is held in the output register.
- `out_ready` in 1: consumer accepts the event.
- `out_ascii` out 8: ASCII code; `00` if unmapped or extended.
- `out_scan` out 8: make code, without prefixes.
- `out_ext` out 1: event was `E0`-prefixed.
- `key_count` out 8: number of emitted events, modulo 256.
- `shift_o` out 1: Shift currently held.
- `caps_o` out 1: Caps Lock latched.
- `ovf_seen` out 1: sticky; set when `in_overflow`=1, cleared only by reset.

## Operation
- **Pop FSM states:**
  - `IDLE` → `POP`, when `in_ready`=1 and the output register is free (`!out_valid`, or `out_valid && out_ready` in the same cycle). `in_data` is captured on this edge.
  - `POP` → `GAP`. `nextdata_n`=0 in this state only.
  - `GAP` → `IDLE`. Lets the FIFO's `ready` update; `in_ready` is ignored in `POP` and `GAP`.
- **Captured byte handling:**
  - `F0`: set `brk`.
  - `E0`: set `ext`.
  - Other byte with `brk`=1 (release):
    - `12` or `59` clears Shift.
    - If the code equals `held`, clear `held_v`.
    - Clear `brk` and `ext`. No event is emitted.
  - Other byte with `brk`=0 (make):
    - Non-extended `12`/`59`: set Shift. No event.
    - Non-extended `58`: toggle Caps. No event.
    - Anything else: emit an event, then set `held`={ext, code} and `held_v`=1. Clear `ext`.
- **Event emission:**
  - Load `out_ascii`, `out_scan` and `out_ext`, and set `out_valid`.
  - Increment `key_count`; it wraps from `FF` to `00`.
- **ASCII lookup:**
  - Letters (scan set 2, `1C`=a … `1A`=z) are uppercase iff Shift XOR Caps.
  - Digits and punctuation use Shift only.
  - `29`→`20`, `5A`→`0D`, `66`→`08`.
  - Extended codes and unmapped codes give `00`; they still emit an event.
- **Handshake:**
  - The event transfers on a cycle with `out_valid && out_ready`; `out_valid` then clears unless a new event loads on the same edge.
  - While the output register is full and not accepted, no byte is popped. `nextdata_n` stays 1, and backpressure reaches the keyboard FIFO.
- **Reset:** an asynchronous assert at any point clears the FSM, `brk`, `ext`, `held_v`, Shift and Caps. A prefix in flight is discarded.

## Timing
- **Reset values:** `nextdata_n`=1; `out_valid`=0; `out_ascii`, `out_scan`, `out_ext`, `key_count`, `shift_o`, `caps_o`, `ovf_seen` all 0.
- **Pop timing:** with the byte captured at edge t, `nextdata_n` is low for exactly cycle t+1. The next capture is possible at edge t+3 at the earliest, so throughput is 1 byte per 3 cycles.
- **Event latency:** `out_valid` and the event data are visible from cycle t+1, i.e. registered, 1 cycle after capture.
- **Simultaneous events:** on an accept and a new capture in the same cycle, the new event replaces the old one; `key_count` increments once.

## Configuration
- `KBD_REPEAT_FILTER_EN`:
  - Defined: a make whose {ext, code} equals `held` while `held_v`=1 is dropped. Typematic repeats produce no event and no count.
  - Undefined: every make emits an event; `held`/`held_v` logic is absent.

## Structure
- **Package `kbd_pkg`:**
  - Constants `SC_BREAK`=`F0`, `SC_EXT`=`E0`, `SC_LSHIFT`=`12`, `SC_RSHIFT`=`59`, `SC_CAPS`=`58`.
  - Pop-FSM state enum `{IDLE, POP, GAP}`.
- **Sub-module `kbd_ascii_lut`:** combinational; inputs (scan, ext, shift, caps), output ascii.

## Test plan
- **Single make:** bytes `1C`, `F0`, `1C`, `out_ready`=1 → one event with ascii `61`, scan `1C`, ext 0; `key_count`=1; `nextdata_n` pulses low 3 times, each 1 cycle wide.
- **Shift:** `12 1C F0 1C F0 12` → one event, ascii `41`; `shift_o` is 1 between `12` and `F0 12`. Then `58 F0 58 1C` → ascii `41` with `caps_o`=1.
- **Repeat filter:** `1C 1C 1C F0 1C` → 1 event with the macro defined, 3 events without it.
- **Extended:** `E0 75 E0 F0 75` → one event with scan `75`, ext 1, ascii `00`; `key_count`=1.
- **Backpressure:** `out_ready`=0, bytes `1C 32` queued → the first event is held and `nextdata_n` stays 1 for the second byte. When `out_ready` rises, `32` is popped and ascii `62` follows.
- **Reset mid-prefix:** `F0`, pulse `resetn` low, then `1C` → a make event (ascii `61`), not a release. Then `in_overflow` pulse → `ovf_seen`=1 sticky until the next reset.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared scancode constants and pop-FSM state type for the PS/2 keyboard decoder.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        GAP
    } pop_state_t;

endpackage

// File: rtl/kbd_ascii_lut.sv
// Scan set 2 make code to ASCII; letters follow Shift XOR Caps, everything else Shift only.
module kbd_ascii_lut (
    input  logic [7:0] scan,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        lo = 8'h00;
        hi = 8'h00;
        case (scan)
            8'h1C: lo = "a";
            8'h32: lo = "b";
            8'h21: lo = "c";
            8'h23: lo = "d";
            8'h24: lo = "e";
            8'h2B: lo = "f";
            8'h34: lo = "g";
            8'h33: lo = "h";
            8'h43: lo = "i";
            8'h3B: lo = "j";
            8'h42: lo = "k";
            8'h4B: lo = "l";
            8'h3A: lo = "m";
            8'h31: lo = "n";
            8'h44: lo = "o";
            8'h4D: lo = "p";
            8'h15: lo = "q";
            8'h2D: lo = "r";
            8'h1B: lo = "s";
            8'h2C: lo = "t";
            8'h3C: lo = "u";
            8'h2A: lo = "v";
            8'h1D: lo = "w";
            8'h22: lo = "x";
            8'h35: lo = "y";
            8'h1A: lo = "z";
            8'h16: begin lo = "1"; hi = "!"; end
            8'h1E: begin lo = "2"; hi = "@"; end
            8'h26: begin lo = "3"; hi = "#"; end
            8'h25: begin lo = "4"; hi = "$"; end
            8'h2E: begin lo = "5"; hi = "%"; end
            8'h36: begin lo = "6"; hi = "^"; end
            8'h3D: begin lo = "7"; hi = "&"; end
            8'h3E: begin lo = "8"; hi = "*"; end
            8'h46: begin lo = "9"; hi = "("; end
            8'h45: begin lo = "0"; hi = ")"; end
            8'h0E: begin lo = 8'h60; hi = "~"; end
            8'h4E: begin lo = "-"; hi = "_"; end
            8'h55: begin lo = "="; hi = "+"; end
            8'h54: begin lo = "["; hi = "{"; end
            8'h5B: begin lo = "]"; hi = "}"; end
            8'h5D: begin lo = 8'h5C; hi = "|"; end
            8'h4C: begin lo = ";"; hi = ":"; end
            8'h52: begin lo = 8'h27; hi = 8'h22; end
            8'h41: begin lo = ","; hi = "<"; end
            8'h49: begin lo = "."; hi = ">"; end
            8'h4A: begin lo = "/"; hi = "?"; end
            8'h29: begin lo = 8'h20; hi = 8'h20; end
            8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
            8'h66: begin lo = 8'h08; hi = 8'h08; end
            default: begin lo = 8'h00; hi = 8'h00; end
        endcase

        // Letters carry no explicit upper entry; the case bit is derived instead.
        if (ext)
            ascii = 8'h00;
        else if (lo >= 8'h61 && lo <= 8'h7A)
            ascii = (shift ^ caps) ? (lo - 8'h20) : lo;
        else
            ascii = shift ? hi : lo;
    end

endmodule

// File: rtl/kbd_decoder.sv
// PS/2 scancode decoder: pops the keyboard FIFO, tracks F0/E0/Shift/Caps, emits key events.
// Optional typematic-repeat suppression when KBD_REPEAT_FILTER_EN is defined.
module kbd_decoder (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_data,
    input  logic       in_ready,
    input  logic       in_overflow,
    output logic       nextdata_n,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_ascii,
    output logic [7:0] out_scan,
    output logic       out_ext,
    output logic [7:0] key_count,
    output logic       shift_o,
    output logic       caps_o,
    output logic       ovf_seen
);
    import kbd_pkg::*;

    pop_state_t state;
    logic       brk;
    logic       ext;
    logic       capture;
    logic       is_prefix;
    logic       is_shift;
    logic       is_caps;
    logic       make_key;
    logic       repeat_hit;
    logic       emit;
    logic [7:0] lut_ascii;

    // A byte is only taken when the event register can absorb its result this edge.
    assign capture   = (state == IDLE) && in_ready && (!out_valid || out_ready);
    assign is_prefix = (in_data == SC_BREAK) || (in_data == SC_EXT);
    assign is_shift  = (in_data == SC_LSHIFT) || (in_data == SC_RSHIFT);
    assign is_caps   = (in_data == SC_CAPS);
    assign make_key  = capture && !brk && !is_prefix && !(!ext && (is_shift || is_caps));
    assign emit      = make_key && !repeat_hit;

`ifdef KBD_REPEAT_FILTER_EN
    logic [8:0] held;
    logic       held_v;

    assign repeat_hit = held_v && (held == {ext, in_data});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held   <= '0;
            held_v <= 1'b0;
        end else if (capture && brk && !is_prefix) begin
            if (held == {ext, in_data})
                held_v <= 1'b0;
        end else if (make_key) begin
            held   <= {ext, in_data};
            held_v <= 1'b1;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    kbd_ascii_lut u_lut (
        .scan  (in_data),
        .ext   (ext),
        .shift (shift_o),
        .caps  (caps_o),
        .ascii (lut_ascii)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            nextdata_n <= 1'b1;
        end else begin
            case (state)
                IDLE: if (capture) begin
                    state      <= POP;
                    nextdata_n <= 1'b0;
                end
                POP: begin
                    state      <= GAP;
                    nextdata_n <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            brk      <= 1'b0;
            ext      <= 1'b0;
            shift_o  <= 1'b0;
            caps_o   <= 1'b0;
            ovf_seen <= 1'b0;
        end else begin
            if (in_overflow)
                ovf_seen <= 1'b1;
            if (capture) begin
                if (in_data == SC_BREAK)
                    brk <= 1'b1;
                else if (in_data == SC_EXT)
                    ext <= 1'b1;
                else if (brk) begin
                    if (is_shift)
                        shift_o <= 1'b0;
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else if (!ext && is_shift)
                    shift_o <= 1'b1;
                else if (!ext && is_caps)
                    caps_o <= !caps_o;
                else
                    ext <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_ascii <= 8'h00;
            out_scan  <= 8'h00;
            out_ext   <= 1'b0;
            key_count <= 8'h00;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_ascii <= lut_ascii;
            out_scan  <= in_data;
            out_ext   <= ext;
            key_count <= key_count + 8'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
